// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-port instruction RAM: fetch (read-only)
// and loader/debug (read/write), one grant per cycle, 1-cycle read latency.
module imem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req_valid,
  input  logic [31:0]       f_req_addr,
  output logic              f_req_ready,
  input  logic              f_flush,
  output logic              f_rsp_valid,
  output logic [31:0]       f_rsp_data,
  input  logic              l_req_valid,
  input  logic              l_req_we,
  input  logic [31:0]       l_req_addr,
  input  logic [31:0]       l_req_wdata,
  output logic              l_req_ready,
  output logic              l_rsp_valid,
  output logic [31:0]       l_rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic [3:0] starve_cnt;
  logic       f_pend;
  logic       l_pend;
  logic       f_starved;
  logic       l_gnt;
  logic       f_gnt;

  // Byte offset and bits above the word index are dropped so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_req_addr[31:ADDR_W+2], f_req_addr[1:0],
                              l_req_addr[31:ADDR_W+2], l_req_addr[1:0]};

  // Grants are held off during reset so nothing accepted there is lost.
  always_comb begin
    f_starved = f_req_valid && (starve_cnt == 4'(STARVE_MAX));
    l_gnt     = !reset && l_req_valid && !f_starved;
    f_gnt     = !reset && f_req_valid && !l_gnt;
  end

  assign f_req_ready = f_gnt;
  assign l_req_ready = l_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_req_we;
      mem_addr  = l_req_addr[ADDR_W+1:2];
      mem_wdata = l_req_wdata;
    end else if (f_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = f_req_addr[ADDR_W+1:2];
    end
  end

  // ---- request / response boundary: owner flags for the cycle-later rdata ----
  always_ff @(posedge clk) begin
    if (reset) begin
      f_pend     <= 1'b0;
      l_pend     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      f_pend <= f_gnt;
      l_pend <= l_gnt && !l_req_we;
      if (!f_req_valid || f_gnt)
        starve_cnt <= '0;
      else if (starve_cnt != 4'(STARVE_MAX))
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // A same-cycle flush kills only the older response; the redirect target
  // fetch accepted alongside it returns normally next cycle.
  always_comb begin
    f_rsp_valid = f_pend && !f_flush && !reset;
    l_rsp_valid = l_pend && !reset;
    f_rsp_data  = f_rsp_valid ? mem_rdata : 32'h0;
    l_rsp_data  = l_rsp_valid ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: directed stimulus pushes expected
// responses; a negedge monitor pops and compares data and arrival cycle.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req_valid, f_flush, f_req_ready, f_rsp_valid;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        l_req_valid, l_req_we, l_req_ready, l_rsp_valid;
  logic [31:0] l_req_addr, l_req_wdata, l_rsp_data;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  imem_arbiter #(.ADDR_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .l_req_valid(l_req_valid), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_ready(l_req_ready),
    .l_rsp_valid(l_rsp_valid), .l_rsp_data(l_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM model
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        mem_rdata     <= mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t fq[$];
  exp_t lq[$];

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (f_rsp_valid === 1'b1) begin
      if (fq.size() == 0) begin
        nchk++;
        $display("FAIL f_rsp_unexpected: got data %h expected no response (cycle %0d)", f_rsp_data, cyc);
      end else begin
        e = fq.pop_front();
        chk("f_rsp_data", f_rsp_data, e.d);
        chk("f_rsp_cycle", cyc, e.c);
      end
    end
    if (l_rsp_valid === 1'b1) begin
      if (lq.size() == 0) begin
        nchk++;
        $display("FAIL l_rsp_unexpected: got data %h expected no response (cycle %0d)", l_rsp_data, cyc);
      end else begin
        e = lq.pop_front();
        chk("l_rsp_data", l_rsp_data, e.d);
        chk("l_rsp_cycle", cyc, e.c);
      end
    end
  end

  task automatic drive(input logic fv, input logic [31:0] fa, input logic fl,
                       input logic lv, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd);
    f_req_valid = fv; f_req_addr = fa; f_flush = fl;
    l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = lwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_f(input logic [31:0] d);
    exp_t e; e.d = d; e.c = cyc + 1; fq.push_back(e);
  endtask

  task automatic push_l(input logic [31:0] d);
    exp_t e; e.d = d; e.c = cyc + 1; lq.push_back(e);
  endtask

  logic [31:0] fetch_addrs [3];
  logic [31:0] fetch_data  [3];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33;
    ram[8] = 32'hAAAA0008; ram[16] = 32'hBBBB0010;
    mem_rdata = 32'h0;
    fetch_addrs[0] = 32'h0;  fetch_addrs[1] = 32'h4;  fetch_addrs[2] = 32'h8;
    fetch_data[0]  = 32'h11; fetch_data[1]  = 32'h22; fetch_data[2]  = 32'h33;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("reset_f_ready", f_req_ready, 0);
    chk("reset_l_ready", l_req_ready, 0);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_rsp_valid", {f_rsp_valid, l_rsp_valid}, 0);
    next_cycle();
    reset = 1'b0;

    // Fetch stream 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      drive(1, fetch_addrs[i], 0, 0, 0, 0, 0);
      push_f(fetch_data[i]);
      @(negedge clk);
      chk("stream_f_ready", f_req_ready, 1);
      chk("stream_mem_addr", mem_addr, i);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Loader write then fetch read of the same address
    drive(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_l_ready", l_req_ready, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 4);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    push_f(32'hDEADBEEF);
    @(negedge clk);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_f_ready", f_req_ready, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Starvation: loader wins 4 cycles, fetch on the 5th, repeating
    drive(1, 32'h4, 0, 1, 0, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) push_f(32'h22);
      else            push_l(32'h11);
      @(negedge clk);
      chk("starve_f_ready", f_req_ready, (i % 5 == 4));
      chk("starve_l_ready", l_req_ready, (i % 5 != 4));
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Flush kills 0x20 response, keeps redirect target 0x40
    drive(1, 32'h20, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 32'h40, 1, 0, 0, 0, 0);
    push_f(32'hBBBB0010);
    @(negedge clk);
    chk("flush_f_rsp_valid", f_rsp_valid, 0);
    chk("flush_f_rsp_data", f_rsp_data, 0);
    chk("flush_f_ready", f_req_ready, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Reset mid-operation: in-flight loader read dropped, starve_cnt cleared
    drive(1, 32'h4, 0, 1, 0, 32'h0, 0);
    push_l(32'h11);
    next_cycle();
    push_l(32'h11);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_l_rsp_valid", l_rsp_valid, 0);
    chk("rst_l_rsp_data", l_rsp_data, 0);
    chk("rst_mem_en", mem_en, 0);
    next_cycle();
    reset = 1'b0;
    push_l(32'h11);
    @(negedge clk);
    chk("post_rst_l_rsp_valid", l_rsp_valid, 0);
    chk("post_rst_l_ready", l_req_ready, 1);
    chk("post_rst_f_ready", f_req_ready, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();

    // Address wrap and ignored byte offset
    drive(1, 32'h404, 0, 0, 0, 0, 0);
    push_f(32'h22);
    @(negedge clk);
    chk("wrap_mem_addr", mem_addr, 1);
    next_cycle();
    drive(1, 32'h5, 0, 0, 0, 0, 0);
    push_f(32'h22);
    @(negedge clk);
    chk("lowbits_mem_addr", mem_addr, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();

    chk("f_queue_drained", fq.size(), 0);
    chk("l_queue_drained", lq.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
